// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller: multiplies V/I samples into power and
// nudges the converter duty toward higher power, settling after every update.
module mppt_po_controller #(
  parameter int DUTY_INIT = 128,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int STEP      = 4,
  parameter int SETTLE    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [7:0]  voltage,
  input  logic [7:0]  current,
  output logic [7:0]  duty,
  output logic        duty_strobe,
  output logic        direction,
  output logic [15:0] power,
  output logic [2:0]  state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [7:0] INIT8 = 8'(DUTY_INIT);
  localparam logic [7:0] MIN8  = 8'(DUTY_MIN);
  localparam logic [7:0] MAX8  = 8'(DUTY_MAX);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MIN9  = 9'(DUTY_MIN);
  localparam logic [8:0] MAX9  = 9'(DUTY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_UPDATE  = 3'd4
  } state_t;

  state_t         cur, nxt;
  logic [7:0]     duty_n, v_lat, i_lat, v_n, i_n;
  logic           dir_n, strobe_n, first, first_n, step_dir;
  logic [15:0]    power_n, prev_power, prev_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [8:0]     up9, dn9;
  logic           dn_under;

  // Stepping is done at 9 bits so overflow past 255 and borrow below 0 both
  // land in the clamp comparisons instead of wrapping silently.
  assign up9      = {1'b0, duty} + STEP9;
  assign dn9      = {1'b0, duty} - STEP9;
  assign dn_under = ({1'b0, duty} < STEP9) || (dn9 < MIN9);

  always_comb begin
    nxt      = cur;
    duty_n   = duty;
    dir_n    = direction;
    power_n  = power;
    prev_n   = prev_power;
    first_n  = first;
    cnt_n    = cnt;
    v_n      = v_lat;
    i_n      = i_lat;
    strobe_n = 1'b0;
    step_dir = direction;
    if (!enable) begin
      nxt   = ST_IDLE;
      cnt_n = '0;
    end else begin
      case (cur)
        ST_IDLE: begin
          nxt     = ST_SETTLE;
          duty_n  = INIT8;
          dir_n   = 1'b1;
          first_n = 1'b1;
          cnt_n   = '0;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt_n = '0;
            nxt   = ST_SAMPLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (sample_valid) begin
            v_n = voltage;
            i_n = current;
            nxt = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          power_n = 16'(v_lat) * 16'(i_lat);
          nxt     = ST_UPDATE;
        end
        ST_UPDATE: begin
          nxt     = ST_SETTLE;
          cnt_n   = '0;
          prev_n  = power;
          first_n = 1'b0;
          // Equal power (after the first sample) leaves duty where it is.
          if (first || (power != prev_power)) begin
            step_dir = (!first && (power < prev_power)) ? ~direction : direction;
            if (step_dir) begin
              if (up9 > MAX9) begin
                duty_n = MAX8;
                dir_n  = 1'b0;
              end else begin
                duty_n = up9[7:0];
                dir_n  = 1'b1;
              end
            end else begin
              if (dn_under) begin
                duty_n = MIN8;
                dir_n  = 1'b1;
              end else begin
                duty_n = dn9[7:0];
                dir_n  = 1'b0;
              end
            end
            strobe_n = (duty_n != duty);
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= ST_IDLE;
      duty        <= INIT8;
      duty_strobe <= 1'b0;
      direction   <= 1'b1;
      power       <= '0;
      prev_power  <= '0;
      first       <= 1'b1;
      cnt         <= '0;
      v_lat       <= '0;
      i_lat       <= '0;
    end else begin
      cur         <= nxt;
      duty        <= duty_n;
      duty_strobe <= strobe_n;
      direction   <= dir_n;
      power       <= power_n;
      prev_power  <= prev_n;
      first       <= first_n;
      cnt         <= cnt_n;
      v_lat       <= v_n;
      i_lat       <= i_n;
    end
  end

  assign state = cur;

endmodule

// File: doc/mppt_po_controller.md
# mppt_po_controller

Perturb-and-observe maximum-power-point tracking (MPPT) controller for the renewable energy converter. It accepts paired voltage/current samples from the front-end and multiplies them to get power. It then steps the converter duty cycle toward higher power, holding each new duty value for a settle window before taking the next sample. It sits between the ADC sample interface and the converter's PWM/conversion datapath, and is the only block that writes the duty setpoint.

## Interface
- DUTY_INIT, 128: duty value loaded at reset and on every enable rising edge.
- DUTY_MIN, 16: lower duty clamp, inclusive.
- DUTY_MAX, 240: upper duty clamp, inclusive.
- STEP, 4: duty perturbation per update; unsigned; must be 1..(DUTY_MAX-DUTY_MIN).
- SETTLE, 8: cycles spent in SETTLE after each duty update; must be ≥1.

- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  tracking enable; low forces IDLE and holds duty.
- sample_valid  input  1  voltage/current pair valid this cycle.
- voltage  input  8  unsigned voltage sample.
- current  input  8  unsigned current sample.
- duty  output  8  duty setpoint to the converter datapath, registered.
- duty_strobe  output  1  one-cycle pulse when duty takes a new value.
- direction  output  1  current perturbation direction: 1 = increasing, 0 = decreasing.
- power  output  16  last computed power, voltage×current, registered.
- state  output  3  FSM state: IDLE=0, SETTLE=1, SAMPLE=2, COMPUTE=3, UPDATE=4.

## Operation
- Reset values:
  - duty=DUTY_INIT, duty_strobe=0, direction=1, power=0, state=IDLE.
  - Internal prev_power=0, first=1, settle counter=0.
- IDLE: when enable=1, load duty=DUTY_INIT, set direction=1 and first=1, then go to SETTLE. No strobe is issued.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE: wait for sample_valid. On the sampling edge, latch voltage and current and go to COMPUTE.
  - sample_valid is ignored in every state except SAMPLE.
- COMPUTE: power <= v_lat*i_lat, a full 16-bit product with no truncation. Go to UPDATE.
- UPDATE: decide direction and step duty, then go to SETTLE.
  - Direction rule:
    - If first=1 or power>prev_power: keep direction.
    - If power<prev_power: invert direction.
    - If power==prev_power: keep direction and leave duty unchanged.
  - Step, unless power was equal: duty ± STEP per direction, computed at 9 bits.
    - If the result exceeds DUTY_MAX, duty=DUTY_MAX and direction forced to 0.
    - If the result is below DUTY_MIN, duty=DUTY_MIN and direction forced to 1.
    - Underflow below 0 counts as below DUTY_MIN.
  - Bookkeeping: prev_power <= power; first <= 0.
  - duty_strobe pulses only if duty actually changed.
- enable=0 in any state moves to IDLE next cycle. duty, direction and power are held; an in-flight sample is discarded.
- Simultaneous enable falling with sample_valid in SAMPLE: enable wins, and the sample is dropped.

## Timing
- Sample accepted at edge N (SAMPLE state, sample_valid=1).
- COMPUTE during cycle N+1; power visible from cycle N+2.
- UPDATE during cycle N+2; new duty and duty_strobe=1 visible in cycle N+3. State is SETTLE in N+3.
- Next sample is accepted no earlier than SETTLE cycles after entering SETTLE.
- Enable rising edge: IDLE→SETTLE on the next edge.
- Asynchronous rst at any time, including mid-COMPUTE or mid-UPDATE, immediately forces all reset values. No strobe is emitted.
- duty_strobe is never high for two consecutive cycles.

## Test plan
- Reset then hold, with enable=0 for 20 cycles → duty=128, direction=1, power=0, state=0, duty_strobe never pulses.
- enable=1; after settle, send v=100, i=50 → power=5000; duty=132 with a single strobe 3 cycles after acceptance; direction=1.
- Next sample v=100, i=60 (6000) → duty=136. Then v=100, i=40 (4000) → direction=0, duty=132.
- Parameters DUTY_INIT=236, STEP=8, DUTY_MAX=240:
  - First sample → duty clamped to 240, direction=0.
  - Next sample with higher power → duty=232.
- Equal power and ignored samples:
  - Equal consecutive samples v=80, i=80 → no duty change, no strobe.
  - sample_valid pulses during SETTLE are ignored; the sample counter is unaffected.
- Interruptions:
  - enable dropped during COMPUTE → IDLE next cycle, duty held, no strobe.
  - rst asserted mid-SETTLE → duty returns to 128 immediately.
